actuator_slot_sequencer: RTL

Time-multiplexes one shared actuator drive stage across NUM_CH actuator channels using round-robin arbitration. Each granted channel gets a fixed-length drive slot, and every slot is preceded by a programmable dead time with all drive outputs low. It sits inside actuator_driver_controller, between the LA-programmed configuration registers and the io_out/io_oeb pad drive bits. It guarantees no shoot-through: a channel's p and n outputs are never high together, and at most one channel is driven at any time.

---
 rtl/act_seq_pkg.sv | 15 +
 rtl/act_rr_arbiter.sv | 34 +++
 rtl/actuator_slot_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/act_seq_pkg.sv
// Shared types and default sizing for the actuator slot sequencer.
// Optional slot counter is enabled by defining ACT_SEQ_SLOT_CNT_EN.
package act_seq_pkg;

  localparam int NUM_CH_DEF = 8;
  localparam int SLOT_W_DEF = 16;
  localparam int DEAD_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    DEAD,
    DRIVE
  } state_e;

endpackage

// File: rtl/act_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr_i,
// wrapping past NUM_CH-1 back to 0.
module act_rr_arbiter #(
  parameter int NUM_CH = 8,
  parameter int PTR_W  = 3
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [PTR_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic              vld_o
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt_o = '0;
    vld_o = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, ptr_i} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(NUM_CH)) begin
        sum = sum - (PTR_W+1)'(NUM_CH);
      end
      idx = sum[PTR_W-1:0];
      if (!vld_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        vld_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/actuator_slot_sequencer.sv
// Round-robin slot sequencer sharing one actuator drive stage, dead time first.
// Define ACT_SEQ_SLOT_CNT_EN to add the slot_count_o completed-slot counter.
module actuator_slot_sequencer
  import act_seq_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int SLOT_W = SLOT_W_DEF,
  parameter int DEAD_W = DEAD_W_DEF
) (
  input  logic                user_clock2,
  input  logic                rst_n,
  input  logic                enable_i,
  input  logic [NUM_CH-1:0]   req_i,
  input  logic [NUM_CH-1:0]   dir_i,
  input  logic [SLOT_W-1:0]   slot_len_i,
  input  logic [DEAD_W-1:0]   dead_len_i,
  output logic [NUM_CH-1:0]   drive_p_o,
  output logic [NUM_CH-1:0]   drive_n_o,
  output logic [2*NUM_CH-1:0] drive_oeb_o,
  output logic [NUM_CH-1:0]   grant_o,
  output logic                busy_o,
  output logic                slot_done_o
`ifdef ACT_SEQ_SLOT_CNT_EN
  ,
  output logic [15:0]         slot_count_o
`endif
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic                dir_q, dir_d;
  logic [SLOT_W-1:0]   slot_cnt_q, slot_cnt_d;
  logic [DEAD_W-1:0]   dead_cnt_q, dead_cnt_d;
  logic [NUM_CH-1:0]   drv_p_q, drv_p_d;
  logic [NUM_CH-1:0]   drv_n_q, drv_n_d;
  logic [2*NUM_CH-1:0] oeb_q, oeb_d;
  logic                done_q, done_d;

  logic [NUM_CH-1:0]   arb_gnt;
  logic                arb_vld;
  logic [PTR_W-1:0]    gidx;
  logic [PTR_W-1:0]    nxt_ptr;
  logic                held;

  act_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_arb (
    .req_i  (req_i),
    .ptr_i  (ptr_q),
    .gnt_o  (arb_gnt),
    .vld_o  (arb_vld)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_q[i]) gidx = PTR_W'(i);
    end
    nxt_ptr = (gidx == PTR_W'(NUM_CH-1)) ? '0 : gidx + PTR_W'(1);
    held    = |(req_i & grant_q);
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    dir_d      = dir_q;
    slot_cnt_d = slot_cnt_q;
    dead_cnt_d = dead_cnt_q;
    drv_p_d    = '0;
    drv_n_d    = '0;
    done_d     = 1'b0;
    oeb_d      = enable_i ? '0 : '1;
    unique case (state_q)
      IDLE: begin
        if (enable_i && arb_vld) begin
          grant_d    = arb_gnt;
          dir_d      = |(dir_i & arb_gnt);
          slot_cnt_d = (slot_len_i == '0) ? SLOT_W'(1) : slot_len_i;
          dead_cnt_d = dead_len_i;
          state_d    = (dead_len_i == '0) ? DRIVE : DEAD;
        end
      end
      DEAD, DRIVE: begin
        if (!enable_i) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (!held ||
                     (state_q == DRIVE && slot_cnt_q == '0)) begin
          state_d = IDLE;
          grant_d = '0;
          done_d  = 1'b1;
          ptr_d   = nxt_ptr;
        end else if (state_q == DEAD) begin
          if (dead_cnt_q == DEAD_W'(1)) state_d = DRIVE;
          else dead_cnt_d = dead_cnt_q - DEAD_W'(1);
        end else begin
          drv_p_d    = dir_q ? '0 : grant_q;
          drv_n_d    = dir_q ? grant_q : '0;
          slot_cnt_d = slot_cnt_q - SLOT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge user_clock2) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      dir_q      <= 1'b0;
      slot_cnt_q <= '0;
      dead_cnt_q <= '0;
      drv_p_q    <= '0;
      drv_n_q    <= '0;
      oeb_q      <= '1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      dir_q      <= dir_d;
      slot_cnt_q <= slot_cnt_d;
      dead_cnt_q <= dead_cnt_d;
      drv_p_q    <= drv_p_d;
      drv_n_q    <= drv_n_d;
      oeb_q      <= oeb_d;
      done_q     <= done_d;
    end
  end

`ifdef ACT_SEQ_SLOT_CNT_EN
  logic [15:0] scnt_q, scnt_d;

  always_comb begin
    scnt_d = done_d ? scnt_q + 16'd1 : scnt_q;
  end

  always_ff @(posedge user_clock2) begin
    if (!rst_n) scnt_q <= '0;
    else        scnt_q <= scnt_d;
  end

  assign slot_count_o = scnt_q;
`endif

  assign drive_p_o   = drv_p_q;
  assign drive_n_o   = drv_n_q;
  assign drive_oeb_o = oeb_q;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != IDLE);
  assign slot_done_o = done_q;

endmodule
